// File: rtl/wb_router_pkg.sv
// Shared types and constants for the Wishbone slave router.
// Holds the FSM state encoding, the error read-back word and the sticky error bit indices.
package wb_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;
  localparam int          ERR_DECODE  = 0;
  localparam int          ERR_TIMEOUT = 1;

  // Wide enough for the largest permitted timeout of 65535 cycles.
  localparam int          TMO_CNT_W   = 16;

  // A new error in the same cycle as a clear keeps its bit set.
  function automatic logic [1:0] err_next(input logic [1:0] cur,
                                          input logic       clr,
                                          input logic [1:0] set);
    return (clr ? 2'b00 : cur) | set;
  endfunction

endpackage

// File: rtl/wb_router_decode.sv
// Address decoder for wb_slave_router: maps the upper address bits to {hit, slave index}.
// Purely combinational; only bits [31:SLV_SHIFT] take part in the decision.
module wb_router_decode
  import wb_router_pkg::*;
#(
  parameter int         NSLV      = 4,
  parameter logic [7:0] BASE_HI   = 8'h30,
  parameter int         SLV_SHIFT = 12,
  parameter int         IDXW      = 2
) (
  input  logic [31-SLV_SHIFT:0] adr_hi,
  output logic                  hit,
  output logic [IDXW-1:0]       idx
);

  logic upper_zero;
  logic base_ok;
  logic idx_ok;

  // Bits between the slave index field and the base byte must be clear.
  always_comb begin
    upper_zero = 1'b1;
    for (int b = IDXW; b < 24 - SLV_SHIFT; b++) begin
      if (adr_hi[b]) upper_zero = 1'b0;
    end
  end

  assign idx     = adr_hi[IDXW-1:0];
  assign base_ok = (adr_hi[31-SLV_SHIFT -: 8] == BASE_HI);
  assign idx_ok  = (int'(idx) < NSLV);
  assign hit     = base_ok && upper_zero && idx_ok;

endmodule

// File: rtl/wb_slave_router.sv
// Wishbone classic router: forwards each upstream transfer to one of NSLV slaves and returns
// a single registered ack. Macro WB_ROUTER_IRQ_EN enables err_irq_o; otherwise it is tied low.
module wb_slave_router
  import wb_router_pkg::*;
#(
  parameter int         NSLV      = 4,
  parameter logic [7:0] BASE_HI   = 8'h30,
  parameter int         SLV_SHIFT = 12,
  parameter int         TIMEOUT   = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [NSLV-1:0]      m_cyc_o,
  output logic [NSLV-1:0]      m_stb_o,
  output logic                 m_we_o,
  output logic [3:0]           m_sel_o,
  output logic [31:0]          m_adr_o,
  output logic [31:0]          m_dat_o,
  input  logic [32*NSLV-1:0]   m_dat_i,
  input  logic [NSLV-1:0]      m_ack_i,
  output logic [1:0]           err_status_o,
  input  logic                 err_clr_i,
  output logic                 err_irq_o
);

  localparam int IDXW = $clog2(NSLV);

  state_t                 state_q, state_d;
  logic [TMO_CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [NSLV-1:0]        sel_oh_q, sel_oh_d;
  logic                   m_we_d;
  logic [3:0]             m_sel_d;
  logic [31:0]            m_adr_d;
  logic [31:0]            m_dat_d;
  logic [31:0]            rdat_d;
  logic                   ack_d;
  logic [1:0]             err_set;
  logic [1:0]             err_d;

  logic                   dec_hit;
  logic [IDXW-1:0]        dec_idx;
  logic [31:0]            slv_dat [NSLV];
  logic                   slv_ack;
  logic [31:0]            slv_rdat;
  logic                   timed_out;

  wb_router_decode #(
    .NSLV      (NSLV),
    .BASE_HI   (BASE_HI),
    .SLV_SHIFT (SLV_SHIFT),
    .IDXW      (IDXW)
  ) u_decode (
    .adr_hi (wbs_adr_i[31:SLV_SHIFT]),
    .hit    (dec_hit),
    .idx    (dec_idx)
  );

  for (genvar g = 0; g < NSLV; g++) begin : g_slv
    assign slv_dat[g] = m_dat_i[32*g +: 32];
  end

  // Only the latched slave's ack and data are ever looked at.
  assign slv_ack   = m_ack_i[idx_q];
  assign slv_rdat  = slv_dat[idx_q];
  assign timed_out = (cnt_q == TMO_CNT_W'(TIMEOUT));

  assign m_cyc_o   = sel_oh_q;
  assign m_stb_o   = sel_oh_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sel_oh_d = sel_oh_q;
    m_we_d   = m_we_o;
    m_sel_d  = m_sel_o;
    m_adr_d  = m_adr_o;
    m_dat_d  = m_dat_o;
    rdat_d   = wbs_dat_o;
    ack_d    = 1'b0;
    err_set  = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          m_we_d  = wbs_we_i;
          m_sel_d = wbs_sel_i;
          m_adr_d = wbs_adr_i;
          m_dat_d = wbs_dat_i;
          cnt_d   = '0;
          if (dec_hit) begin
            state_d = ST_FWD;
            idx_d   = dec_idx;
            for (int i = 0; i < NSLV; i++) begin
              sel_oh_d[i] = (dec_idx == IDXW'(i));
            end
          end else begin
            state_d              = ST_RESP;
            rdat_d               = ERR_DATA;
            ack_d                = 1'b1;
            err_set[ERR_DECODE]  = 1'b1;
          end
        end
      end
      ST_FWD: begin
        // Master abort beats everything; a slave ack beats the timeout.
        if (!wbs_cyc_i) begin
          state_d  = ST_IDLE;
          sel_oh_d = '0;
          cnt_d    = '0;
        end else if (slv_ack) begin
          state_d  = ST_RESP;
          sel_oh_d = '0;
          cnt_d    = '0;
          rdat_d   = m_we_o ? 32'h0 : slv_rdat;
          ack_d    = 1'b1;
        end else if (timed_out) begin
          state_d              = ST_RESP;
          sel_oh_d             = '0;
          cnt_d                = '0;
          rdat_d               = ERR_DATA;
          ack_d                = 1'b1;
          err_set[ERR_TIMEOUT] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        sel_oh_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  assign err_d = err_next(err_status_o, err_clr_i, err_set);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      sel_oh_q     <= '0;
      m_we_o       <= 1'b0;
      m_sel_o      <= 4'h0;
      m_adr_o      <= 32'h0;
      m_dat_o      <= 32'h0;
      wbs_dat_o    <= 32'h0;
      wbs_ack_o    <= 1'b0;
      err_status_o <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sel_oh_q     <= sel_oh_d;
      m_we_o       <= m_we_d;
      m_sel_o      <= m_sel_d;
      m_adr_o      <= m_adr_d;
      m_dat_o      <= m_dat_d;
      wbs_dat_o    <= rdat_d;
      wbs_ack_o    <= ack_d;
      err_status_o <= err_d;
    end
  end

`ifdef WB_ROUTER_IRQ_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) err_irq_o <= 1'b0;
    else          err_irq_o <= |err_d;
  end
`else
  assign err_irq_o = 1'b0;
`endif

endmodule
